trdb_branch_map_mr: RTL and testbench

Multi-retire, parametrised successor of the trace debugger's single-branch branch map. It accepts up to RETIRE retired instructions per cycle and packs the taken/not-taken outcomes of their conditional branches into MAPLEN-bit branch maps. It closes a map when the map fills or on flush, and queues closed maps in a DEPTH-entry output buffer with valid/ready handshake. It sits between the per-slot instruction classifier and the packet priority/emitter stage.

---
 rtl/trdb_branch_map_mr_pkg.sv | 14 +
 rtl/trdb_branch_map_mr_fifo.sv | 53 +++++
 rtl/trdb_branch_map_mr.sv | 106 ++++++++++
 tb/tb_trdb_branch_map_mr.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trdb_branch_map_mr_pkg.sv
// Shared defaults and constants for the multi-retire branch map.
package trdb_branch_map_mr_pkg;

    localparam int TRDB_BMAP_LEN_DEFAULT   = 31;
    localparam int TRDB_RETIRE_DEFAULT     = 2;
    localparam int TRDB_BMAP_DEPTH_DEFAULT = 2;

    // Reason a map was closed; stored as the top bit of each queued entry.
    typedef enum logic {
        CLOSE_FLUSH = 1'b0,
        CLOSE_FULL  = 1'b1
    } close_reason_e;

endpackage

// File: rtl/trdb_branch_map_mr_fifo.sv
// Generic DEPTH-entry FIFO with two ordered push ports (port 0 lands first) and one pop port.
module trdb_bmap_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 37,
    localparam int PW   = $clog2(DEPTH),
    localparam int OCCW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push0_i,
    input  logic [WIDTH-1:0] data0_i,
    input  logic             push1_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [OCCW-1:0]  occ_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [OCCW-1:0]  occ_q;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid_o = (occ_q != '0);
    assign pop     = pop_i & valid_o;
    assign occ_o   = occ_q;
    assign head_o  = valid_o ? mem[rd_ptr_q] : '0;

    // push1 is only ever raised together with push0, so port 1 takes the slot after port 0.
    always_ff @(posedge clk_i) begin
        if (push0_i) mem[wr_ptr_q] <= data0_i;
        if (push1_i) mem[ptr_inc(wr_ptr_q)] <= data1_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push0_i && push1_i) wr_ptr_q <= ptr_inc(ptr_inc(wr_ptr_q));
            else if (push0_i)       wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            occ_q <= occ_q + OCCW'(push0_i) + OCCW'(push1_i) - OCCW'(pop);
        end
    end

endmodule

// File: rtl/trdb_branch_map_mr.sv
// Packs up to RETIRE branch outcomes per cycle into MAPLEN-bit maps and queues closed maps.
module trdb_branch_map_mr
    import trdb_branch_map_mr_pkg::*;
#(
    parameter int RETIRE  = TRDB_RETIRE_DEFAULT,
    parameter int MAPLEN  = TRDB_BMAP_LEN_DEFAULT,
    parameter int DEPTH   = TRDB_BMAP_DEPTH_DEFAULT,
    localparam int CNTW   = $clog2(MAPLEN + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [RETIRE-1:0] valid_i,
    input  logic [RETIRE-1:0] branch_i,
    input  logic [RETIRE-1:0] taken_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [CNTW-1:0]   cur_cnt_o,
    output logic              cur_empty_o,
    output logic              map_valid_o,
    input  logic              map_ready_i,
    output logic [MAPLEN-1:0] map_o,
    output logic [CNTW-1:0]   map_cnt_o,
    output logic              map_full_o
);

    localparam int EW   = MAPLEN + CNTW + 1;
    localparam int OCCW = $clog2(DEPTH + 1);
    localparam logic [CNTW:0] ONE_W    = (CNTW + 1)'(1);
    localparam logic [CNTW:0] MAPLEN_W = (CNTW + 1)'(MAPLEN);

    logic [MAPLEN-1:0] map_q, map_work, map_next, full_map;
    logic [CNTW-1:0]   cnt_q, cnt_next;
    logic [CNTW:0]     cnt_work;
    logic              full_push, flush_push, accept;
    logic              push0, push1;
    logic [EW-1:0]     full_entry, flush_entry, data0, head;
    logic [OCCW-1:0]   occ;

    assign accept = ~stall_o;

    // Append branches in slot order; a fill mid-cycle closes the map and the rest spill to bit 0.
    always_comb begin
        map_work  = map_q;
        cnt_work  = {1'b0, cnt_q};
        full_map  = '0;
        full_push = 1'b0;
        for (int k = 0; k < RETIRE; k++) begin
            if (valid_i[k] && branch_i[k]) begin
                map_work[cnt_work[CNTW-1:0]] = taken_i[k];
                cnt_work = cnt_work + ONE_W;
                if (cnt_work == MAPLEN_W) begin
                    full_map  = map_work;
                    full_push = 1'b1;
                    map_work  = '0;
                    cnt_work  = '0;
                end
            end
        end
        flush_push = flush_i && (cnt_work != '0);
        map_next   = flush_i ? '0 : map_work;
        cnt_next   = flush_i ? '0 : cnt_work[CNTW-1:0];
    end

    assign full_entry  = {CLOSE_FULL, CNTW'(MAPLEN), full_map};
    assign flush_entry = {CLOSE_FLUSH, cnt_work[CNTW-1:0], map_work};

    // The full map always goes ahead of a flushed spill in the same cycle.
    assign push0 = accept & (full_push | flush_push);
    assign push1 = accept & full_push & flush_push;
    assign data0 = full_push ? full_entry : flush_entry;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            map_q <= map_next;
            cnt_q <= cnt_next;
        end
    end

    trdb_bmap_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push0_i (push0),
        .data0_i (data0),
        .push1_i (push1),
        .data1_i (flush_entry),
        .pop_i   (map_ready_i),
        .head_o  (head),
        .valid_o (map_valid_o),
        .occ_o   (occ)
    );

    // Registered occupancy only, so two pushes always fit whenever input is accepted.
    assign stall_o     = (occ > OCCW'(DEPTH - 2));
    assign cur_cnt_o   = cnt_q;
    assign cur_empty_o = (cnt_q == '0);
    assign map_o       = head[MAPLEN-1:0];
    assign map_cnt_o   = head[MAPLEN+:CNTW];
    assign map_full_o  = head[EW-1];

endmodule

// File: tb/tb_trdb_branch_map_mr.sv
// Directed bench for trdb_branch_map_mr at RETIRE=2, MAPLEN=31, DEPTH=2.
module tb_trdb_branch_map_mr;

    localparam int RETIRE = 2;
    localparam int MAPLEN = 31;
    localparam int DEPTH  = 2;
    localparam int CNTW   = 5;
    localparam int EW     = MAPLEN + CNTW + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [RETIRE-1:0] valid_i = '0, branch_i = '0, taken_i = '0;
    logic              flush_i = 1'b0;
    logic              stall_o, cur_empty_o, map_valid_o, map_full_o;
    logic              map_ready_i = 1'b1;
    logic [CNTW-1:0]   cur_cnt_o, map_cnt_o;
    logic [MAPLEN-1:0] map_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic [1:0]    valid;
        logic [1:0]    branch;
        logic [1:0]    taken;
        logic          flush;
        logic          push;
        logic [EW-1:0] entry;
        int            exp_cnt;
    } vec_t;
    vec_t tbl[6];

    trdb_branch_map_mr #(
        .RETIRE (RETIRE),
        .MAPLEN (MAPLEN),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .branch_i    (branch_i),
        .taken_i     (taken_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .cur_cnt_o   (cur_cnt_o),
        .cur_empty_o (cur_empty_o),
        .map_valid_o (map_valid_o),
        .map_ready_i (map_ready_i),
        .map_o       (map_o),
        .map_cnt_o   (map_cnt_o),
        .map_full_o  (map_full_o)
    );

    // Clock and watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every pop is compared with the oldest expected entry
    always @(negedge clk_i) begin
        if (rst_ni && map_valid_o && map_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got 0x%0h, required no entry", {map_full_o, map_cnt_o, map_o});
            end else begin
                check("pop_entry", 64'({map_full_o, map_cnt_o, map_o}), 64'(exp_q.pop_front()));
            end
        end
    end

    // Driver: holds inputs until the block accepts them, then returns #1 after that edge
    task automatic drive(input logic [1:0] v, input logic [1:0] b, input logic [1:0] t, input logic f);
        int w;
        valid_i  = v;
        branch_i = b;
        taken_i  = t;
        flush_i  = f;
        w = 0;
        while (stall_o && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        if (stall_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall_timeout: stall_o=1 after %0d cycles, required 0", w);
        end
        @(posedge clk_i);
        #1;
        valid_i  = '0;
        branch_i = '0;
        taken_i  = '0;
        flush_i  = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_stall"},     64'(stall_o),     64'(0));
        check({tag, "_cur_cnt"},   64'(cur_cnt_o),   64'(0));
        check({tag, "_cur_empty"}, 64'(cur_empty_o), 64'(1));
        check({tag, "_map_valid"}, 64'(map_valid_o), 64'(0));
        check({tag, "_map"},       64'(map_o),       64'(0));
        check({tag, "_map_cnt"},   64'(map_cnt_o),   64'(0));
        check({tag, "_map_full"},  64'(map_full_o),  64'(0));
    endtask

    task automatic reset_mid_run();
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check_reset_values("rst_during");
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_values("rst_held");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_reset_values("rst_after");
    endtask

    initial begin
        tbl[0] = '{2'b01, 2'b01, 2'b01, 1'b0, 1'b0, '0, 1};
        tbl[1] = '{2'b11, 2'b10, 2'b01, 1'b0, 1'b0, '0, 2};
        tbl[2] = '{2'b10, 2'b11, 2'b11, 1'b0, 1'b0, '0, 3};
        tbl[3] = '{2'b11, 2'b11, 2'b01, 1'b0, 1'b0, '0, 5};
        tbl[4] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b1, {1'b0, 5'd5, 31'h0000000D}, 0};
        tbl[5] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0, '0, 0};

        #1;
        check_reset_values("rst_initial");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 31 taken branches in slot 0 close one full map
        for (int i = 0; i < 31; i++) begin
            if (i == 30) exp_q.push_back({1'b1, 5'd31, 31'h7FFFFFFF});
            drive(2'b01, 2'b01, 2'b01, 1'b0);
            if (i == 29) begin
                check("fill_cnt30", 64'(cur_cnt_o), 64'(30));
                check("fill_no_valid", 64'(map_valid_o), 64'(0));
            end
        end
        check("fill_valid", 64'(map_valid_o), 64'(1));
        check("fill_map", 64'(map_o), 64'h7FFFFFFF);
        check("fill_map_cnt", 64'(map_cnt_o), 64'(31));
        check("fill_map_full", 64'(map_full_o), 64'(1));
        check("fill_cur_cnt", 64'(cur_cnt_o), 64'(0));

        // Spill: 30 not-taken, then slot0 taken fills, slot1 not-taken spills
        for (int i = 0; i < 15; i++) drive(2'b11, 2'b11, 2'b00, 1'b0);
        check("spill_cnt30", 64'(cur_cnt_o), 64'(30));
        exp_q.push_back({1'b1, 5'd31, 31'h40000000});
        drive(2'b11, 2'b11, 2'b01, 1'b0);
        check("spill_cur_cnt", 64'(cur_cnt_o), 64'(1));
        exp_q.push_back({1'b0, 5'd1, 31'h00000000});
        drive(2'b00, 2'b00, 2'b00, 1'b1);
        check("spill_flush_cnt", 64'(cur_cnt_o), 64'(0));

        // Table: mixed slot patterns, flush, then flush on an empty map
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].push) exp_q.push_back(tbl[i].entry);
            drive(tbl[i].valid, tbl[i].branch, tbl[i].taken, tbl[i].flush);
            check($sformatf("tbl%0d_cnt", i), 64'(cur_cnt_o), 64'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d_empty", i), 64'(cur_empty_o), 64'(tbl[i].exp_cnt == 0));
        end

        // Exact fill together with flush: one full entry, nothing for the flush
        for (int i = 0; i < 14; i++) drive(2'b11, 2'b11, 2'b10, 1'b0);
        drive(2'b01, 2'b01, 2'b01, 1'b0);
        check("exact_cnt29", 64'(cur_cnt_o), 64'(29));
        exp_q.push_back({1'b1, 5'd31, 31'h7AAAAAAA});
        drive(2'b11, 2'b11, 2'b11, 1'b1);
        check("exact_cur_cnt", 64'(cur_cnt_o), 64'(0));
        check("exact_cur_empty", 64'(cur_empty_o), 64'(1));
        repeat (4) @(posedge clk_i);
        #1;
        check("exact_drained", 64'(exp_q.size()), 64'(0));

        // Backpressure with map_ready_i low
        map_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) drive(2'b11, 2'b11, 2'b11, 1'b0);
        exp_q.push_back({1'b1, 5'd31, 31'h3FFFFFFF});
        drive(2'b11, 2'b11, 2'b10, 1'b0);
        check("bp_stall", 64'(stall_o), 64'(1));
        check("bp_valid", 64'(map_valid_o), 64'(1));
        check("bp_cur_cnt", 64'(cur_cnt_o), 64'(1));
        valid_i  = 2'b11;
        branch_i = 2'b11;
        taken_i  = 2'b11;
        flush_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check($sformatf("bp_hold_cnt%0d", i), 64'(cur_cnt_o), 64'(1));
            check($sformatf("bp_hold_stall%0d", i), 64'(stall_o), 64'(1));
            check($sformatf("bp_hold_head%0d", i), 64'({map_full_o, map_cnt_o, map_o}),
                  64'({1'b1, 5'd31, 31'h3FFFFFFF}));
        end
        valid_i  = '0;
        branch_i = '0;
        taken_i  = '0;
        flush_i  = 1'b0;
        map_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        map_ready_i = 1'b0;
        check("bp_unstall", 64'(stall_o), 64'(0));
        check("bp_popped", 64'(map_valid_o), 64'(0));
        map_ready_i = 1'b1;
        exp_q.push_back({1'b0, 5'd1, 31'h00000001});
        drive(2'b00, 2'b00, 2'b00, 1'b1);

        // Reset mid-map, then a queued entry discarded by reset
        for (int i = 0; i < 6; i++) drive(2'b11, 2'b11, 2'b01, 1'b0);
        check("rst_pre_cnt", 64'(cur_cnt_o), 64'(12));
        reset_mid_run();
        map_ready_i = 1'b0;
        drive(2'b01, 2'b01, 2'b01, 1'b1);
        check("post_rst_head", 64'({map_full_o, map_cnt_o, map_o}), 64'({1'b0, 5'd1, 31'h00000001}));
        check("post_rst_valid", 64'(map_valid_o), 64'(1));
        check("post_rst_stall", 64'(stall_o), 64'(1));
        reset_mid_run();
        map_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
